// File: rtl/t05_stage_tracker.sv
// t05_stage_tracker: stage-side companion of the compression controller.
// Tracks per-stage completion (finState), issues one-cycle start pulses on
// stage entry, flags out-of-order done pulses (err_seq) and, when built with
// T05_STAGE_TRACKER_WATCHDOG_EN defined, raises a sticky stall flag when a
// stage stays active too long without completing.
// Bit order of done/finState/stage_start: {idle,HG,FLV,HT,FINISHED,CBS,TRN,SPI}.
module t05_stage_tracker #(
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       restart_en,
  input  logic       ht_loop,
  input  logic [7:0] done,
  output logic [7:0] finState,
  output logic [7:0] stage_start,
  output logic       all_done,
  output logic       err_seq,
  output logic       stall
);

  localparam logic [2:0] BIT_SPI = 3'd0;
  localparam logic [2:0] BIT_HT  = 3'd4;
  localparam logic [2:0] BIT_FLV = 3'd5;

  logic [3:0] prev_state;
  logic       act_valid;
  logic [2:0] act_bit;
  logic [7:0] act_mask;
  logic       acc;
  logic       stray;
  logic       start_fire;
  logic       spi_clear;
  logic [7:0] fin_next;
  logic       all_done_next;

  // Map the controller state code onto its finState bit
  always_comb begin
    act_valid = 1'b1;
    act_bit   = 3'd0;
    unique case (state)
      4'd0:    act_bit = 3'd7;
      4'd1:    act_bit = 3'd6;
      4'd2:    act_bit = 3'd5;
      4'd3:    act_bit = 3'd4;
      4'd4:    act_bit = 3'd3;
      4'd5:    act_bit = 3'd2;
      4'd6:    act_bit = 3'd1;
      4'd8:    act_bit = 3'd0;
      default: act_valid = 1'b0;
    endcase
  end

  assign act_mask   = act_valid ? (8'b1 << act_bit) : 8'b0;
  assign acc        = |(done & act_mask);
  assign stray      = |(done & ~act_mask);
  assign start_fire = !restart_en && act_valid && (state != prev_state);
  assign spi_clear  = (finState == 8'hFF);

  // Completion update for an accepted done, including the FLV/HT loop swap
  always_comb begin
    fin_next      = finState;
    all_done_next = 1'b0;
    if (acc) begin
      if (act_bit == BIT_SPI) begin
        fin_next      = 8'hFF;
        all_done_next = 1'b1;
      end else if (act_bit == BIT_HT) begin
        fin_next[BIT_HT] = 1'b1;
        if (ht_loop) fin_next[BIT_FLV] = 1'b0;
      end else if (act_bit == BIT_FLV) begin
        fin_next[BIT_FLV] = 1'b1;
        fin_next[BIT_HT]  = 1'b0;
      end else begin
        fin_next = finState | act_mask;
      end
    end
  end

  // Main tracker registers: restart beats the SPI auto-clear, which beats done handling
  always_ff @(posedge clk) begin
    if (!rst) begin
      finState    <= 8'h00;
      stage_start <= 8'h00;
      all_done    <= 1'b0;
      err_seq     <= 1'b0;
      prev_state  <= 4'd0;
    end else begin
      prev_state  <= state;
      stage_start <= start_fire ? act_mask : 8'h00;
      all_done    <= 1'b0;
      if (restart_en) begin
        finState <= 8'h00;
        err_seq  <= 1'b0;
      end else if (spi_clear) begin
        finState <= 8'h00;
      end else begin
        finState <= fin_next;
        all_done <= all_done_next;
        if (stray) err_seq <= 1'b1;
      end
    end
  end

`ifdef T05_STAGE_TRACKER_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_next;
  logic              acc_eff;

  assign acc_eff = acc && !restart_en && !spi_clear;

  // Watchdog restarts on stage entry, real progress, or in the parked states
  always_comb begin
    if (start_fire || acc_eff || state == 4'd0 || state == 4'd4)
      wdog_next = '0;
    else if (wdog == WDOG_LIMIT)
      wdog_next = wdog;
    else
      wdog_next = wdog + 1'b1;
  end

  // Counter and sticky stall; only reset clears stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog  <= '0;
      stall <= 1'b0;
    end else begin
      wdog <= wdog_next;
      if (wdog_next == WDOG_LIMIT) stall <= 1'b1;
    end
  end
`else
  // Watchdog not built; the comparison keeps the limit parameter referenced
  assign stall = 1'b0 && (WDOG_LIMIT == '0);
`endif

endmodule

// File: doc/t05_stage_tracker.md
Name: t05_stage_tracker

Overview:
- Stage-side counterpart of the compression controller.
- Consumes the controller's 4-bit state code and collects one-cycle done pulses from the pipeline stages: idle, HG, FLV, HT, FINISHED, CBS, TRN, SPI.
- Builds the registered 8-bit finState vector the controller decodes. Issues a one-cycle start pulse to each stage when the controller enters that stage.
- Also flags out-of-order completions and, optionally, stalled stages.

Parameters:
- WDOG_W, 16, width of the stall watchdog counter (used only with the optional feature).
- WDOG_LIMIT, 16'hFFFF, cycles a stage may stay active without a done pulse before stall is raised.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous and active-low: the block resets on the clk edge where rst==0.
- state  input  4  controller state code: 0 IDLE, 1 HG, 2 FLV, 3 HT, 4 FINISHED, 5 CBS, 6 TRN, 8 SPI; others are invalid.
- restart_en  input  1  clears all progress.
- ht_loop  input  1  qualifies HT done: tree is not complete, so return to FLV.
- done  input  8  per-stage done pulses {idle,HG,FLV,HT,FINISHED,CBS,TRN,SPI}, bit 7 = idle.
- finState  output  8  completion vector, same bit order as done.
- stage_start  output  8  one-hot start pulse, same bit order.
- all_done  output  1  one-cycle pulse when SPI completes.
- err_seq  output  1  sticky: a done arrived for a stage that is not active.
- stall  output  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset values: finState=0, stage_start=0, all_done=0, err_seq=0, stall=0, prev_state=0, watchdog=0.
- Active bit mapping from state: 0→7, 1→6, 2→5, 3→4, 4→3, 5→2, 6→1, 8→0. Invalid codes (7, 9–15) give no active bit.
- Done acceptance:
  - Only done[active bit] is accepted.
  - An accepted pulse sets that finState bit on the next clk edge (1-cycle latency).
  - Any other done bit that is high sets err_seq and is otherwise ignored.
  - Done bits and err_seq are evaluated independently in the same cycle.
- HT loop handling:
  - HT done with ht_loop=1: set bit 4 and clear bit 5 in the same update (e.g. 11100000→11010000). The controller then returns to FLV.
  - FLV done while bit 4 is set: set bit 5 and clear bit 4 (11010000→11100000).
  - HT done with ht_loop=0: set bit 4 and leave bit 5 set (11100000→11110000).
- SPI completion:
  - On SPI done, finState becomes 8'hFF for exactly one cycle and all_done pulses in that same cycle.
  - On the next edge finState returns to 0 automatically. The controller then decodes 0 and goes to IDLE.
- Start pulses:
  - prev_state is registered every cycle.
  - When state≠prev_state and state is valid, stage_start[active bit] is high for exactly one cycle, registered and aligned to the cycle after the change.
  - A FLV↔HT loop revisit produces a fresh pulse each time.
  - No pulse while state is unchanged. No pulse on entry to an invalid code.
- Priority, highest first: reset, then restart_en, then the SPI auto-clear, then done processing.
  - restart_en=1 clears finState and err_seq and suppresses stage_start and all_done that cycle; done pulses that cycle are discarded. stall is not cleared by restart_en.
  - stage_start is suppressed during reset and restart. prev_state still updates.
- Reset mid-operation: all registers return to their reset values. Done pulses in the reset cycle are dropped.
- Done pulses are level-sampled every cycle. A done held high for multiple cycles re-sets an already-set bit, which is harmless. It does not re-trigger all_done unless finState was cleared in between.

Optional Feature:
- Macro: T05_STAGE_TRACKER_WATCHDOG_EN.
- Defined:
  - A WDOG_W-bit counter resets to 0 on any stage_start pulse, on any accepted done, and while state is 0 or 4.
  - Otherwise it increments, saturating at WDOG_LIMIT.
  - Reaching WDOG_LIMIT sets stall, which is sticky until rst; restart_en does not clear it.
- Undefined: no counter is instantiated and stall is tied to 0.

Test Plan:
- Normal run: drive state 0,1,2,3,4,5,6,8 with the matching done pulse each step, ht_loop=0 → finState goes 80,C0,E0,F0,F8,FC,FE,FF then 00; all_done pulses once; err_seq stays 0; one stage_start per entry.
- HT loop: at finState=E0, state=3, done HT with ht_loop=1 → D0; then state=2, done FLV → E0; stage_start[5] pulses again on re-entry.
- Out-of-order: state=1, pulse done[2] (CBS) → finState unchanged, err_seq=1 next cycle and held; restart_en=1 → err_seq=0, finState=00.
- Simultaneous: state=5, done={CBS,TRN} in one cycle → bit 2 set, bit 1 clear, err_seq=1.
- Reset mid-run: at finState=F8 assert rst=0 for one edge together with a done → all outputs 0; the done is dropped.
- Watchdog (macro defined, WDOG_LIMIT=10): enter state=2, withhold done → stall=1 after 10 cycles; repeat with the macro undefined → stall stays 0.
